// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Data-memory / peripheral bus between the load/store unit and the memory
// system. A request is transferred on bus_req_valid & bus_req_ready. Every
// accepted request (load or store) is answered by exactly one bus_rsp_valid
// beat, optionally qualified by bus_rsp_err.
//
//   bus_req_valid  LSU -> mem  request valid
//   bus_req_ready  mem -> LSU  request accepted when valid & ready
//   bus_addr       LSU -> mem  word-aligned byte address
//   bus_we         LSU -> mem  1 = write
//   bus_be         LSU -> mem  byte enables
//   bus_wdata      LSU -> mem  lane-replicated store data
//   bus_rsp_valid  mem -> LSU  response beat
//   bus_rsp_err    mem -> LSU  error qualifier on the response
//   bus_rdata      mem -> LSU  raw word read data
//
// Modports: master = LSU side, slave = memory side.
// ----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic        bus_rsp_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Turns the MEM-stage access into a word-aligned bus transaction with byte
// enables, stalls the pipeline while the bus is busy, and returns aligned,
// sign/zero-extended load data registered for the WB stage one cycle after
// the access completes. Misaligned/illegal accesses, bus errors and bus
// timeouts are reported through lsu_err / lsu_err_cause.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   mem_addr/mem_wdata       MEM-stage byte address and unaligned store data
//   mem_op                   fun3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   mem_write/mem_read       store / load request (both set = store)
//   mem_rdata                aligned load data, valid the cycle after DONE
//   lsu_stall                holds IF..MEM pipeline registers
//   lsu_err                  one-cycle pulse in DONE on a faulted access
//   lsu_err_cause            00 ok, 01 misaligned/illegal, 10 bus err, 11 timeout
//   bus                      load_store_unit_if.master
//
// Parameter TIMEOUT_CYCLES (1..65535): cycles waited in REQ or RESP before
// the access is abandoned with a timeout.
//
// Build option LSU_FAST_IDLE_EN: when defined, a legal access is presented
// on the bus combinationally already in IDLE, saving one stall cycle when
// the bus accepts immediately.
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_op,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] mem_rdata,
  output logic        lsu_stall,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_cause,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  op_reg;
  logic [1:0]  lane_reg;
  logic        req_valid_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  cause_reg;
  logic        err_reg;
  logic [31:0] rdata_cap_reg;
  logic [31:0] mem_rdata_reg;

  // --------------------------------------------------------------------------
  // Decode and format the incoming access
  // --------------------------------------------------------------------------
  logic        access;
  logic [1:0]  size;
  logic        illegal_op;
  logic        misaligned;
  logic        fault_now;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  assign access     = mem_read | mem_write;
  assign size       = mem_op[1:0];
  assign illegal_op = (mem_op == 3'b011) || (mem_op[2:1] == 2'b11);
  assign misaligned = ((size == 2'b01) && mem_addr[0]) ||
                      ((size == 2'b10) && (mem_addr[1:0] != 2'b00));
  assign fault_now  = illegal_op | misaligned;

  always_comb begin
    req_be = 4'b1111;
    if (mem_write) begin
      case (size)
        2'b00:   req_be = 4'b0001 << mem_addr[1:0];
        2'b01:   req_be = mem_addr[1] ? 4'b1100 : 4'b0011;
        default: req_be = 4'b1111;
      endcase
    end
  end

  // Replicate the store byte/halfword onto every lane so the byte enables
  // alone pick the destination.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
      assign req_wdata[gi*8 +: 8] = (size == 2'b00) ? mem_wdata[7:0] :
                                    (size == 2'b01) ? mem_wdata[(gi%2)*8 +: 8] :
                                                      mem_wdata[gi*8 +: 8];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Load alignment from the latched lane and op
  // --------------------------------------------------------------------------
  logic [31:0] shifted;
  logic [31:0] aligned;

  assign shifted = bus.bus_rdata >> {lane_reg, 3'b000};

  always_comb begin
    aligned = shifted;
    case (op_reg)
      3'b000:  aligned = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  aligned = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  aligned = {24'd0, shifted[7:0]};
      3'b101:  aligned = {16'd0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fast IDLE path: legal access goes out on the bus without a REQ cycle
  // --------------------------------------------------------------------------
  logic fast_req;
`ifdef LSU_FAST_IDLE_EN
  assign fast_req = (state_reg == IDLE) && access && !fault_now;
`else
  assign fast_req = 1'b0;
`endif

  assign bus.bus_req_valid = req_valid_reg | fast_req;
  assign bus.bus_addr      = fast_req ? {mem_addr[31:2], 2'b00} : addr_reg;
  assign bus.bus_we        = fast_req ? mem_write : we_reg;
  assign bus.bus_be        = fast_req ? req_be    : be_reg;
  assign bus.bus_wdata     = fast_req ? req_wdata : wdata_reg;

  assign lsu_stall     = (state_reg == IDLE) ? access
                                             : ((state_reg == REQ) || (state_reg == RESP));
  assign lsu_err       = err_reg;
  assign lsu_err_cause = cause_reg;
  assign mem_rdata     = mem_rdata_reg;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      op_reg        <= '0;
      lane_reg      <= '0;
      req_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      cause_reg     <= CAUSE_NONE;
      err_reg       <= 1'b0;
      rdata_cap_reg <= '0;
      mem_rdata_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (access) begin
            we_reg <= mem_write;
            if (fault_now) begin
              // No bus transaction for a misaligned or illegal access.
              state_reg <= DONE;
              cause_reg <= CAUSE_ALIGN;
              err_reg   <= 1'b1;
            end else begin
              addr_reg  <= {mem_addr[31:2], 2'b00};
              be_reg    <= req_be;
              wdata_reg <= req_wdata;
              op_reg    <= mem_op;
              lane_reg  <= mem_addr[1:0];
              if (fast_req && bus.bus_req_ready) begin
                state_reg <= RESP;
              end else begin
                state_reg     <= REQ;
                req_valid_reg <= 1'b1;
              end
            end
          end
        end

        REQ: begin
          if (bus.bus_req_ready) begin
            state_reg     <= RESP;
            req_valid_reg <= 1'b0;
            cnt_reg       <= '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg     <= DONE;
            req_valid_reg <= 1'b0;
            cause_reg     <= CAUSE_TIMEOUT;
            err_reg       <= 1'b1;
            cnt_reg       <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        RESP: begin
          if (bus.bus_rsp_valid) begin
            state_reg     <= DONE;
            cnt_reg       <= '0;
            rdata_cap_reg <= aligned;
            cause_reg     <= bus.bus_rsp_err ? CAUSE_BUS : CAUSE_NONE;
            err_reg       <= bus.bus_rsp_err;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            cause_reg <= CAUSE_TIMEOUT;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        DONE: begin
          // Never re-issue: DONE always returns to IDLE. Loads publish
          // their data (zero if faulted); stores leave mem_rdata alone.
          state_reg <= IDLE;
          cnt_reg   <= '0;
          if (!we_reg) begin
            mem_rdata_reg <= (cause_reg == CAUSE_NONE) ? rdata_cap_reg : 32'd0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with TIMEOUT_CYCLES = 4. Inputs change
// and outputs are sampled shortly after the falling edge. Expected stall and
// request-valid counts follow the LSU_FAST_IDLE_EN build option.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

`ifdef LSU_FAST_IDLE_EN
  localparam int GOOD_STALL = 2;
  localparam int TO_VALID   = 5;
`else
  localparam int GOOD_STALL = 3;
  localparam int TO_VALID   = 4;
`endif
  localparam int TO_STALL = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_op = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] mem_rdata;
  logic        lsu_stall;
  logic        lsu_err;
  logic [1:0]  lsu_err_cause;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_op        (mem_op),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .mem_rdata     (mem_rdata),
    .lsu_stall     (lsu_stall),
    .lsu_err       (lsu_err),
    .lsu_err_cause (lsu_err_cause),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations of the last access
  int          obs_stall;
  int          obs_valid;
  logic        obs_err;
  logic [1:0]  obs_cause;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_we;
  logic [31:0] obs_rdata;

  // Drives one access and acts as a memory that answers one cycle after
  // acceptance. Records what was seen until DONE (lsu_stall low), then
  // samples mem_rdata one cycle later.
  task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic w, input logic r,
                            input logic [31:0] rdata, input logic rerr, input logic rdy);
    logic done;
    logic acc_pending;
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_wdata = wdata; mem_write = w; mem_read = r;
    bus_if.bus_rdata = rdata; bus_if.bus_rsp_err = rerr;
    bus_if.bus_req_ready = rdy; bus_if.bus_rsp_valid = 1'b0;
    obs_stall = 0; obs_valid = 0; obs_err = 1'b0; obs_cause = 2'b00;
    obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
    done = 1'b0; acc_pending = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (c > 0) @(negedge clk);
      bus_if.bus_rsp_valid = acc_pending;
      acc_pending = 1'b0;
      #1;
      if (lsu_stall) obs_stall++;
      else begin
        done = 1'b1;
        obs_err = lsu_err;
        obs_cause = lsu_err_cause;
      end
      if (bus_if.bus_req_valid) begin
        obs_valid++;
        obs_addr = bus_if.bus_addr; obs_be = bus_if.bus_be;
        obs_wdata = bus_if.bus_wdata; obs_we = bus_if.bus_we;
        if (bus_if.bus_req_ready) acc_pending = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_done: stall never dropped, got stall=%0d cycles, required DONE within 30", obs_stall);
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_if.bus_rsp_valid = 1'b0;
    @(negedge clk); #1;
    obs_rdata = mem_rdata;
    $display("ACCESS op=%b addr=%h we=%b stall=%0d valid=%0d be=%b wdata=%h err=%b cause=%b rdata=%h",
             op, addr, w, obs_stall, obs_valid, obs_be, obs_wdata, obs_err, obs_cause, obs_rdata);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rsp_err = 1'b0; bus_if.bus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_rdata, lsu_stall, lsu_err, lsu_err_cause} !== 36'd0) begin
      errors++;
      $display("FAIL reset_core: got rdata=%h stall=%b err=%b cause=%b, required all 0",
               mem_rdata, lsu_stall, lsu_err, lsu_err_cause);
    end
    checks++;
    if ({bus_if.bus_req_valid, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata} !== 70'd0) begin
      errors++;
      $display("FAIL reset_bus: got valid=%b we=%b be=%b addr=%h wdata=%h, required all 0",
               bus_if.bus_req_valid, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_access(3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    checks++;
    if (obs_stall != GOOD_STALL) begin errors++; $display("FAIL lw_stall: got %0d, required %0d", obs_stall, GOOD_STALL); end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h, required deadbeef", obs_rdata); end
    checks++;
    if (obs_be !== 4'b1111 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
      errors++; $display("FAIL lw_bus: got be=%b addr=%h we=%b, required be=1111 addr=00000100 we=0", obs_be, obs_addr, obs_we);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_cause !== 2'b00) begin
      errors++; $display("FAIL lw_err: got err=%b cause=%b, required 0/00", obs_err, obs_cause);
    end
  endtask

  task automatic test_store();
    run_access(3'b001, 32'h0202, 32'h1234ABCD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (obs_addr !== 32'h200 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_we !== 1'b1) begin
      errors++; $display("FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b, required 00000200 1100 abcdabcd 1",
                         obs_addr, obs_be, obs_wdata, obs_we);
    end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sh_rdata_hold: got %h, required deadbeef", obs_rdata); end
    // SB to byte 1, and both read and write set counts as a store
    run_access(3'b000, 32'h0301, 32'h000000A5, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (obs_addr !== 32'h300 || obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5 || obs_we !== 1'b1) begin
      errors++; $display("FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b, required 00000300 0010 a5a5a5a5 1",
                         obs_addr, obs_be, obs_wdata, obs_we);
    end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF || obs_stall != GOOD_STALL) begin
      errors++; $display("FAIL sb_rdata_stall: got rdata=%h stall=%0d, required deadbeef %0d", obs_rdata, obs_stall, GOOD_STALL);
    end
  endtask

  task automatic test_misaligned();
    run_access(3'b010, 32'h101, 32'h0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1);
    checks++;
    if (obs_valid != 0 || obs_stall != 1) begin
      errors++; $display("FAIL mis_lw_bus: got valid=%0d stall=%0d, required 0 1", obs_valid, obs_stall);
    end
    checks++;
    if (obs_err !== 1'b1 || obs_cause !== 2'b01 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL mis_lw_err: got err=%b cause=%b rdata=%h, required 1 01 00000000", obs_err, obs_cause, obs_rdata);
    end
    run_access(3'b110, 32'h100, 32'h0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1);
    checks++;
    if (obs_valid != 0 || obs_err !== 1'b1 || obs_cause !== 2'b01) begin
      errors++; $display("FAIL illegal_op: got valid=%0d err=%b cause=%b, required 0 1 01", obs_valid, obs_err, obs_cause);
    end
  endtask

  task automatic test_load_ext();
    run_access(3'b000, 32'h103, 32'h0, 1'b0, 1'b1, 32'h80FF0000, 1'b0, 1'b1);
    checks++;
    if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h, required ffffff80", obs_rdata); end
    run_access(3'b100, 32'h103, 32'h0, 1'b0, 1'b1, 32'h80FF0000, 1'b0, 1'b1);
    checks++;
    if (obs_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h, required 00000080", obs_rdata); end
    run_access(3'b101, 32'h102, 32'h0, 1'b0, 1'b1, 32'h80FF0000, 1'b0, 1'b1);
    checks++;
    if (obs_rdata !== 32'h000080FF || obs_addr !== 32'h100) begin
      errors++; $display("FAIL lhu_zext: got rdata=%h addr=%h, required 000080ff 00000100", obs_rdata, obs_addr);
    end
    run_access(3'b001, 32'h102, 32'h0, 1'b0, 1'b1, 32'h80FF0000, 1'b0, 1'b1);
    checks++;
    if (obs_rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_sext: got %h, required ffff80ff", obs_rdata); end
  endtask

  task automatic test_bus_err();
    run_access(3'b010, 32'h110, 32'h0, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b1);
    checks++;
    if (obs_err !== 1'b1 || obs_cause !== 2'b10 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL bus_err: got err=%b cause=%b rdata=%h, required 1 10 00000000", obs_err, obs_cause, obs_rdata);
    end
  endtask

  task automatic test_timeout();
    run_access(3'b010, 32'h400, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs_stall != TO_STALL || obs_valid != TO_VALID) begin
      errors++; $display("FAIL timeout_len: got stall=%0d valid=%0d, required %0d %0d", obs_stall, obs_valid, TO_STALL, TO_VALID);
    end
    checks++;
    if (obs_err !== 1'b1 || obs_cause !== 2'b11) begin
      errors++; $display("FAIL timeout_cause: got err=%b cause=%b, required 1 11", obs_err, obs_cause);
    end
    // Late response must not restart anything
    @(negedge clk);
    bus_if.bus_req_ready = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    #1;
    checks++;
    if (lsu_stall !== 1'b0 || bus_if.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL late_rsp_a: got stall=%b valid=%b, required 0 0", lsu_stall, bus_if.bus_req_valid);
    end
    @(negedge clk);
    bus_if.bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (lsu_err !== 1'b0 || lsu_stall !== 1'b0 || lsu_err_cause !== 2'b11) begin
      errors++; $display("FAIL late_rsp_b: got err=%b stall=%b cause=%b, required 0 0 11", lsu_err, lsu_stall, lsu_err_cause);
    end
  endtask

  task automatic test_reset_mid();
    logic accepted;
    run_access(3'b010, 32'h108, 32'h0, 1'b0, 1'b1, 32'h2468ACE0, 1'b0, 1'b1);
    checks++;
    if (obs_rdata !== 32'h2468ACE0) begin errors++; $display("FAIL pre_reset_lw: got %h, required 2468ace0", obs_rdata); end
    // Start a load and reset it while waiting for the response
    @(negedge clk);
    mem_op = 3'b010; mem_addr = 32'h10C; mem_read = 1'b1; mem_write = 1'b0;
    bus_if.bus_req_ready = 1'b1; bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_err = 1'b0;
    bus_if.bus_rdata = 32'hBAD0BAD0;
    accepted = 1'b0;
    for (int c = 0; c < 10 && !accepted; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus_if.bus_req_valid && bus_if.bus_req_ready) accepted = 1'b1;
    end
    @(negedge clk); #1;
    checks++;
    if (!accepted || lsu_stall !== 1'b1 || bus_if.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL in_resp: got accepted=%b stall=%b valid=%b, required 1 1 0", accepted, lsu_stall, bus_if.bus_req_valid);
    end
    reset_n = 1'b0; mem_read = 1'b0;
    #1;
    checks++;
    if (lsu_stall !== 1'b0 || bus_if.bus_req_valid !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset: got stall=%b valid=%b rdata=%h, required 0 0 00000000",
                         lsu_stall, bus_if.bus_req_valid, mem_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    @(negedge clk);
    bus_if.bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if (lsu_stall !== 1'b0 || lsu_err !== 1'b0 || bus_if.bus_req_valid !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL stale_rsp: got stall=%b err=%b valid=%b rdata=%h, required 0 0 0 00000000",
                         lsu_stall, lsu_err, bus_if.bus_req_valid, mem_rdata);
    end
    run_access(3'b010, 32'h104, 32'h0, 1'b0, 1'b1, 32'h13579BDF, 1'b0, 1'b1);
    checks++;
    if (obs_rdata !== 32'h13579BDF || obs_stall != GOOD_STALL || obs_cause !== 2'b00) begin
      errors++; $display("FAIL post_reset_lw: got rdata=%h stall=%0d cause=%b, required 13579bdf %0d 00",
                         obs_rdata, obs_stall, obs_cause, GOOD_STALL);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_store();
    test_misaligned();
    test_load_ext();
    test_bus_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
